// File: rtl/transfer_engine_pkg.sv
`default_nettype none
// ============================================================================
// Package : transfer_engine_pkg
// Brief   : Shared FSM state encoding and width helpers for the transfer engine.
// Revision: 1.0 - initial release
// ============================================================================
package transfer_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_XFER   = 2'd2,
        ST_FINISH = 2'd3
    } xfer_state_t;

    // Length field must hold MAX_BEATS itself, hence the +1.
    function automatic int len_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter; priority restarts after the last granted req.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import transfer_engine_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = ch_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] r_ptr;
    int               w_cand;

    // Scan from the highest offset down so the closest requester to r_ptr wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        w_cand      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (|(req_i & (N'(1) << w_cand))) begin
                any_o       = 1'b1;
                grant_idx_o = IDX_W'(w_cand);
            end
        end
        if (any_o) begin
            grant_o = N'(1) << grant_idx_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance_i && any_o) begin
            r_ptr <= (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_channel_transfer_engine.sv
`default_nettype none
// ============================================================================
// Module  : multi_channel_transfer_engine
// Brief   : Multi-channel beat streamer with bounds checking, abort and RR grant.
// Revision: 1.0 - initial release
// ============================================================================
module multi_channel_transfer_engine
    import transfer_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 32,
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    localparam int LEN_W = len_w(MAX_BEATS),
    localparam int CH_W  = ch_w(NUM_CH)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [NUM_CH-1:0]                      start_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]           src_address_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]           dst_address_i,
    input  logic [NUM_CH*LEN_W-1:0]                len_i,
    input  logic [NUM_CH*MAX_BEATS*DATA_WIDTH-1:0] data_in_i,
    input  logic                                   abort_i,
    output logic                                   out_valid_o,
    output logic [DATA_WIDTH-1:0]                  out_data_o,
    output logic [ADDR_WIDTH-1:0]                  out_addr_o,
    output logic [CH_W-1:0]                        out_ch_o,
    output logic                                   out_last_o,
    input  logic                                   out_ready_i,
    output logic [NUM_CH-1:0]                      done_o,
    output logic [NUM_CH-1:0]                      error_o,
    output logic                                   busy_o
);

    localparam int PAYLOAD_W = MAX_BEATS * DATA_WIDTH;
    localparam int SUM_W     = ADDR_WIDTH + 2;
    localparam logic [SUM_W-1:0] c_addr_span = {2'b01, {ADDR_WIDTH{1'b0}}};

    xfer_state_t           r_state;
    logic [NUM_CH-1:0]     r_pending;
    logic [CH_W-1:0]       r_ch;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [LEN_W-1:0]      r_len;
    logic [PAYLOAD_W-1:0]  r_payload;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_last;
    logic [NUM_CH-1:0]     r_done;
    logic [NUM_CH-1:0]     r_error;

    logic [NUM_CH-1:0]     w_grant;
    logic [CH_W-1:0]       w_grant_idx;
    logic                  w_any;
    logic [NUM_CH-1:0]     w_ch_mask;
    logic [NUM_CH-1:0]     w_active;
    logic                  w_take;
    logic [NUM_CH-1:0]     w_pending_d;
    logic                  w_hs;
    logic [SUM_W-1:0]      w_src_end;
    logic [SUM_W-1:0]      w_dst_end;
    logic                  w_check_err;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic [ADDR_WIDTH-1:0] w_beat_addr;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk         (clk_i),
        .rst         (reset_i),
        .req_i       (r_pending),
        .advance_i   (w_take),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .any_o       (w_any)
    );

    always_comb begin
        w_ch_mask   = NUM_CH'(1) << r_ch;
        w_active    = (r_state != ST_IDLE) ? w_ch_mask : '0;
        w_take      = (r_state == ST_IDLE) && w_any;
        // A start on a pending or in-flight channel is dropped.
        w_pending_d = (r_pending | (start_i & ~w_active)) & ~(w_take ? w_grant : '0);
        w_hs        = r_valid && out_ready_i;
        w_src_end   = SUM_W'(r_src) + SUM_W'(r_len);
        w_dst_end   = SUM_W'(r_dst) + SUM_W'(r_len);
        w_check_err = (r_len == '0) || (r_len > LEN_W'(MAX_BEATS)) ||
                      (w_src_end > c_addr_span) || (w_dst_end > c_addr_span);
        w_beat_data = r_payload[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH];
        w_beat_addr = r_dst + ADDR_WIDTH'(r_cnt);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_ch      <= '0;
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_payload <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_addr    <= '0;
            r_last    <= 1'b0;
            r_done    <= '0;
            r_error   <= '0;
        end else begin
            r_pending <= w_pending_d;
            r_done    <= '0;
            r_error   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_ch      <= w_grant_idx;
                        r_src     <= src_address_i[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_dst     <= dst_address_i[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_len     <= len_i[int'(w_grant_idx)*LEN_W +: LEN_W];
                        r_payload <= data_in_i[int'(w_grant_idx)*PAYLOAD_W +: PAYLOAD_W];
                        r_cnt     <= '0;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_check_err) begin
                        r_done  <= w_ch_mask;
                        r_error <= w_ch_mask;
                        r_state <= ST_FINISH;
                    end else begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A handshake on the last beat wins over a simultaneous abort.
                    if (w_hs && r_last) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= w_ch_mask;
                        r_state <= ST_FINISH;
                    end else if (abort_i) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= w_ch_mask;
                        r_error <= w_ch_mask;
                        r_state <= ST_FINISH;
                    end else if (w_hs || !r_valid) begin
                        r_valid <= 1'b1;
                        r_data  <= w_beat_data;
                        r_addr  <= w_beat_addr;
                        r_last  <= (r_cnt == r_len - 1'b1);
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign out_addr_o  = r_addr;
    assign out_ch_o    = r_ch;
    assign out_last_o  = r_last;
    assign done_o      = r_done;
    assign error_o     = r_error;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/multi_channel_transfer_engine.md
MULTI_CHANNEL_TRANSFER_ENGINE -- requirements
Module: multi_channel_transfer_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the beat width in bits.
REQ-002 The block SHALL have parameter MAX_BEATS, default 32, meaning the maximum beats per transfer; LEN_W = clog2(MAX_BEATS+1).
REQ-003 The block SHALL have parameter NUM_CH, default 2, meaning the channel count (>=1).
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the address width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start_i, input, NUM_CH bits: per-channel transfer request pulse.
REQ-008 The block SHALL have ports src_address_i and dst_address_i, input, NUM_CH*ADDR_WIDTH bits each: per-channel base addresses.
REQ-009 The block SHALL have port len_i, input, NUM_CH*LEN_W bits: per-channel beat count.
REQ-010 The block SHALL have port data_in_i, input, NUM_CH*MAX_BEATS*DATA_WIDTH bits: per-channel payload.
REQ-011 The block SHALL have port abort_i, input, 1 bit: cancels the active transfer.
REQ-012 The block SHALL have outputs out_valid_o (1), out_data_o (DATA_WIDTH), out_addr_o (ADDR_WIDTH), out_ch_o (clog2(NUM_CH), min 1) and out_last_o (1), plus input out_ready_i (1): the beat stream.
REQ-013 The block SHALL have outputs done_o and error_o, NUM_CH bits each (per-channel one-cycle pulses), and output busy_o (1).

Function
REQ-014 start_i[c] SHALL set a sticky pending[c] bit at the sampling edge; start_i[c] SHALL be ignored while channel c is pending or active.
REQ-015 The FSM SHALL have states IDLE, CHECK, XFER and FINISH, with busy_o high in every state except IDLE.
REQ-016 In IDLE with any pending bit set, a round-robin grant SHALL start from the channel after the last granted one; that channel's pending bit SHALL be cleared and its addresses, length and payload snapshotted; the FSM SHALL go to CHECK.
REQ-017 CHECK (one cycle) SHALL flag an error if len==0, len>MAX_BEATS, src+len>2^ADDR_WIDTH or dst+len>2^ADDR_WIDTH, using ADDR_WIDTH+1-bit arithmetic with no wrap; on error go to FINISH, else go to XFER.
REQ-018 Beat k (k = 0..len-1) SHALL carry out_data_o = payload[k*DATA_WIDTH +: DATA_WIDTH] (LSB first), out_addr_o = dst+k and out_ch_o = the granted channel, with out_last_o high on k = len-1.
REQ-019 out_valid_o SHALL stay high and the beat fields stable until out_valid_o && out_ready_i; the beat count SHALL advance only on that handshake; there SHALL be no combinational path from out_ready_i to out_valid_o.
REQ-020 The handshake on the last beat SHALL move the FSM to FINISH.
REQ-021 FINISH (one cycle) SHALL pulse done_o[ch], pulse error_o[ch] as well if the transfer failed, and return to IDLE.
REQ-022 From an idle engine, the first out_valid_o SHALL rise 3 edges after the start_i sampling edge (grant, CHECK, XFER).
REQ-023 abort_i in XFER SHALL drop all remaining beats and go to FINISH with an error; a handshake in the same cycle SHALL count as delivered; if that beat was the last, the transfer SHALL complete without error.
REQ-024 abort_i outside XFER SHALL be ignored.
REQ-025 Snapshot inputs changing after the grant SHALL NOT affect the transfer in flight.

Reset
REQ-026 While reset_i is high, the FSM SHALL be in IDLE, all pending bits and the round-robin pointer SHALL be 0 (channel 0 first), and out_valid_o, out_last_o, done_o, error_o and busy_o SHALL be 0; out_data_o, out_addr_o and out_ch_o SHALL be 0.
REQ-027 Reset mid-transfer SHALL discard the transfer and all pending requests without any done_o or error_o pulse.

Structure
REQ-028 Package transfer_engine_pkg SHALL hold the FSM state enum and the LEN_W/channel-index width helper functions.
REQ-029 Round-robin grant SHALL be a sub-module rr_arbiter #(N) with request/grant/advance ports; the datapath SHALL stay in the top.

Verification
REQ-030 NUM_CH=2, ch0 len=32, dst=0x2000, payload 0x0102..1F20, out_ready_i held 1: 32 beats 0x20,0x1F..0x01 at 0x2000..0x201F, out_last_o on beat 31, done_o[0] pulse, error_o=0.
REQ-031 Beat stream with out_ready_i toggling every other cycle: out_valid_o never drops and the beat fields are held, with the same data sequence as REQ-030.
REQ-032 Simultaneous start on ch0 and ch1: ch0 is served first and then ch1; out_ch_o correct per beat; both done_o pulses occur.
REQ-033 ch1 len=0, and separately dst=0xFFF0 with len=32: no beats, done_o[1] and error_o[1] pulse in FINISH.
REQ-034 abort_i asserted after beat 5 handshake: no further beats, done_o[0] and error_o[0] pulse, the next pending channel then proceeds.
REQ-035 reset_i asserted mid-transfer: all outputs are 0 immediately with no pulses; a new start afterwards completes normally.
